// File: rtl/farm_request_generator.sv
// Farm-road request front end: synchronises and debounces the loop detector, latches
// vehicle requests for the traffic light controller and watches its lights for service/faults.
module farm_request_generator #(
  parameter int unsigned TICK_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_WAIT_TICKS  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       loop_raw,
  input  logic [2:0] light_highway,
  input  logic [2:0] light_farm,
  output logic       C,
  output logic       loop_db,
  output logic [3:0] queue_cnt,
  output logic       wait_alarm,
  output logic       light_fault,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVE   = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  localparam logic [2:0]        GREEN     = 3'b001;
  localparam logic [2:0]        YELLOW    = 3'b010;
  localparam int unsigned       PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]        DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]       WAIT_MAX  = 16'(MAX_WAIT_TICKS);

  state_t        state;
  logic          s1, s2, loop_db_q, arrival;
  logic [7:0]    db_cnt;
  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   wait_cnt, wait_inc;
  logic [3:0]    pending, pend_sum, queue_inc;
  logic          hw_ok, farm_ok, bad_lights;

  assign fsm_state = state;

  // Synchroniser, debouncer and registered rising-edge detect of the debounced loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      db_cnt    <= '0;
      loop_db   <= 1'b0;
      loop_db_q <= 1'b0;
      arrival   <= 1'b0;
    end else begin
      s1        <= loop_raw;
      s2        <= s1;
      loop_db_q <= loop_db;
      arrival   <= loop_db & ~loop_db_q;
      if (s2 == loop_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        loop_db <= s2;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
    end
  end

  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= tick ? '0 : presc + 1'b1;
  end

  always_comb begin
    queue_inc  = (queue_cnt == 4'd15) ? 4'd15 : queue_cnt + 4'd1;
    pend_sum   = (arrival && pending != 4'd15) ? pending + 4'd1 : pending;
    wait_inc   = (tick && wait_cnt < WAIT_MAX) ? wait_cnt + 16'd1 : wait_cnt;
    hw_ok      = light_highway inside {3'b001, 3'b010, 3'b100};
    farm_ok    = light_farm inside {3'b001, 3'b010, 3'b100};
    bad_lights = !hw_ok || !farm_ok || (light_highway == GREEN && light_farm == GREEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) light_fault <= 1'b0;
    else        light_fault <= light_fault | bad_lights;
  end

  // Exact-match light compares mean illegal codes never move the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      C          <= 1'b0;
      queue_cnt  <= 4'd0;
      wait_cnt   <= 16'd0;
      wait_alarm <= 1'b0;
      pending    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (arrival || (loop_db && loop_db_q)) begin
            state     <= REQUEST;
            C         <= 1'b1;
            queue_cnt <= 4'd1;
          end
        end
        REQUEST: begin
          if (light_farm == GREEN) begin
            state      <= SERVE;
            C          <= 1'b0;
            queue_cnt  <= 4'd0;
            wait_cnt   <= 16'd0;
            wait_alarm <= 1'b0;
          end else begin
            if (arrival) queue_cnt <= queue_inc;
            wait_cnt <= wait_inc;
            if (wait_inc == WAIT_MAX) wait_alarm <= 1'b1;
          end
        end
        SERVE: begin
          if (light_farm == YELLOW) state <= CLEAR;
        end
        CLEAR: begin
          if (light_highway == GREEN) begin
            pending <= 4'd0;
            if (pend_sum != 4'd0 || loop_db) begin
              state     <= REQUEST;
              C         <= 1'b1;
              queue_cnt <= (pend_sum != 4'd0) ? pend_sum : 4'd1;
            end else begin
              state <= IDLE;
            end
          end else begin
            pending <= pend_sum;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
